// File: rtl/multi_delay.sv
// multi_delay: NCH independent programmable delay/period channels.
// Each channel counts from 0 up to its period and then either wraps
// (periodic) or parks in DONE (one-shot). Period and mode are written
// through a shared configuration port. Sticky error bits flag counters
// that ran past their period and writes aimed at nonexistent channels.
module multi_delay #(
    parameter int NCH       = 4,
    parameter int CBITS     = 13,
    parameter int DEFAULT_N = 7500,
    parameter int CHBITS    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      start,
    input  logic [NCH-1:0]      stop,
    input  logic                cfg_we,
    input  logic [CHBITS-1:0]   cfg_ch,
    input  logic [CBITS-1:0]    cfg_period,
    input  logic                cfg_mode,
    input  logic                err_clr,
    output logic [NCH-1:0]      sig,
    output logic [NCH-1:0]      flg,
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      err,
    output logic                cfg_err,
    output logic [2*NCH-1:0]    dbg_state
);

    // Channel state; encoding is visible on dbg_state (2 bits per channel).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CHBITS:0] NCH_W = (CHBITS+1)'(NCH);

    state_e           state_q  [NCH];
    logic [CBITS-1:0] cnt_q    [NCH];
    logic [CBITS-1:0] period_q [NCH];
    logic             mode_q   [NCH];   // 0 = periodic, 1 = one-shot
    logic [NCH-1:0]   err_q;
    logic             cfg_err_q;
    logic             cfg_ch_ok;

    assign cfg_ch_ok = ({1'b0, cfg_ch} < NCH_W);

    // Channel FSMs, counters, configuration registers and sticky errors.
    // Priority per channel: stop, then start (retrigger), then counting.
    // Terminal test uses the period held before any same-cycle config write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= IDLE;
                cnt_q[c]    <= '0;
                period_q[c] <= CBITS'(DEFAULT_N);
                mode_q[c]   <= 1'b0;
            end
            err_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                // Overrun is a set condition and beats err_clr.
                if (state_q[c] == RUN && cnt_q[c] > period_q[c]) begin
                    err_q[c] <= 1'b1;
                end else if (err_clr) begin
                    err_q[c] <= 1'b0;
                end

                if (stop[c]) begin
                    state_q[c] <= IDLE;
                    cnt_q[c]   <= '0;
                end else if (start[c]) begin
                    state_q[c] <= RUN;
                    cnt_q[c]   <= '0;
                end else if (state_q[c] == RUN) begin
                    if (cnt_q[c] >= period_q[c]) begin
                        cnt_q[c]   <= '0;
                        state_q[c] <= mode_q[c] ? DONE : RUN;
                    end else begin
                        cnt_q[c] <= cnt_q[c] + CBITS'(1);
                    end
                end else begin
                    cnt_q[c] <= '0;
                end

                if (cfg_we && cfg_ch_ok && cfg_ch == CHBITS'(c)) begin
                    period_q[c] <= cfg_period;
                    mode_q[c]   <= cfg_mode;
                end
            end

            if (cfg_we && !cfg_ch_ok) begin
                cfg_err_q <= 1'b1;
            end else if (err_clr) begin
                cfg_err_q <= 1'b0;
            end
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        sig       = '0;
        flg       = '0;
        done      = '0;
        dbg_state = '0;
        for (int c = 0; c < NCH; c++) begin
            sig[c]             = (state_q[c] == RUN) && (cnt_q[c] >= period_q[c]);
            flg[c]             = (state_q[c] == RUN) && (cnt_q[c] <  period_q[c]);
            done[c]            = (state_q[c] == DONE);
            dbg_state[2*c +: 2] = state_q[c];
        end
    end

    assign err     = err_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_delay.sv
// Bench for multi_delay with NCH=2, CBITS=4, DEFAULT_N=5: directed
// scenarios followed by random traffic, all compared cycle by cycle
// against a behavioural channel model.
module tb_multi_delay;

    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     start, stop;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [3:0]     cfg_period;
    logic           cfg_mode;
    logic           err_clr;
    logic [1:0]     sig, flg, done, err;
    logic           cfg_err;
    logic [3:0]     dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: phase 0 = idle, 1 = running, 2 = expired one-shot.
    int m_phase [NCH];
    int m_cnt   [NCH];
    int m_per   [NCH];
    int m_oneshot [NCH];
    int m_err   [NCH];
    int m_cfg_err;

    int sig_cycles[$];

    multi_delay #(
        .NCH(2), .CBITS(4), .DEFAULT_N(5), .CHBITS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .err_clr(err_clr),
        .sig(sig), .flg(flg), .done(done), .err(err),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0; m_cnt[c] = 0; m_per[c] = 5;
            m_oneshot[c] = 0; m_err[c] = 0;
        end
        m_cfg_err = 0;
    endtask

    // One clock of the model, applying the channel rules to the inputs
    // seen at this edge.
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_phase[c] == 1 && m_cnt[c] > m_per[c]) m_err[c] = 1;
            else if (err_clr) m_err[c] = 0;
            if (stop[c]) begin
                m_phase[c] = 0; m_cnt[c] = 0;
            end else if (start[c]) begin
                m_phase[c] = 1; m_cnt[c] = 0;
            end else if (m_phase[c] == 1) begin
                if (m_cnt[c] >= m_per[c]) begin
                    m_cnt[c] = 0;
                    if (m_oneshot[c] != 0) m_phase[c] = 2;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
            m_per[int'(cfg_ch)]     = int'(cfg_period);
            m_oneshot[int'(cfg_ch)] = int'(cfg_mode);
        end
        if (cfg_we && int'(cfg_ch) >= NCH) m_cfg_err = 1;
        else if (err_clr) m_cfg_err = 0;
    endtask

    task automatic compare_all();
        logic [1:0] e_sig, e_flg, e_done, e_err;
        for (int c = 0; c < NCH; c++) begin
            e_sig[c]  = (m_phase[c] == 1) && (m_cnt[c] >= m_per[c]);
            e_flg[c]  = (m_phase[c] == 1) && (m_cnt[c] <  m_per[c]);
            e_done[c] = (m_phase[c] == 2);
            e_err[c]  = (m_err[c] != 0);
        end
        check("sig",     16'(sig),     16'(e_sig));
        check("flg",     16'(flg),     16'(e_flg));
        check("done",    16'(done),    16'(e_done));
        check("err",     16'(err),     16'(e_err));
        check("cfg_err", 16'(cfg_err), 16'(m_cfg_err != 0));
    endtask

    // Apply one cycle of inputs, clock it, advance the model, compare.
    task automatic cyc(input logic [1:0] st, input logic [1:0] sp,
                       input logic we, input logic [1:0] ch, input logic [3:0] per,
                       input logic md, input logic clr, input logic r);
        start = st; stop = sp; cfg_we = we; cfg_ch = ch;
        cfg_period = per; cfg_mode = md; err_clr = clr; rst = r;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        start = '0; stop = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_mode = 1'b0; err_clr = 1'b0; rst = 1'b1;

        // Reset state
        cyc(2'b00, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("rst_outputs", {8'h0, sig, flg, done, err}, 16'h0);
        check("rst_cfg_err", 16'(cfg_err), 16'h0);

        // Periodic default period 5: sig at cycles 6, 12, 18 after start
        cyc(2'b01, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 18; j++) begin
            idle(1);
            if (sig[0]) sig_cycles.push_back(j + 1);
        end
        check("periodic_count", 16'(sig_cycles.size()), 16'd3);
        if (sig_cycles.size() == 3) begin
            check("periodic_t1", 16'(sig_cycles[0]), 16'd6);
            check("periodic_t2", 16'(sig_cycles[1]), 16'd12);
            check("periodic_t3", 16'(sig_cycles[2]), 16'd18);
        end

        // One-shot on channel 1 with period 3
        cyc(2'b00, 2'b00, 1'b1, 2'd1, 4'd3, 1'b1, 1'b0, 1'b0);
        cyc(2'b10, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("oneshot_sig", 16'(sig[1]), 16'd1);
        idle(1);
        check("oneshot_done", 16'(done[1]), 16'd1);
        check("oneshot_flg", 16'(flg[1]), 16'd0);
        idle(8);
        check("oneshot_quiet", 16'(sig[1]), 16'd0);

        // Lower ch0 period under a running count
        cyc(2'b01, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(4);
        cyc(2'b00, 2'b00, 1'b1, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("overrun_err", 16'(err[0]), 16'd1);
        idle(7);
        cyc(2'b00, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        check("err_clr", 16'(err[0]), 16'd0);

        // start+stop together: stop wins; later retrigger at cnt 3
        cyc(2'b01, 2'b01, 1'b1, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        check("stop_wins", {14'h0, flg[0], sig[0]}, 16'h0);
        cyc(2'b01, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        cyc(2'b01, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("retrig_early", 16'(sig[0]), 16'd0);
        idle(1);
        check("retrig_sig", 16'(sig[0]), 16'd1);

        // Zero period: sig every cycle while running
        cyc(2'b00, 2'b00, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("zero_period", 16'(sig[0]), 16'd1);

        // Invalid channel write, then reset mid-count
        cyc(2'b10, 2'b00, 1'b1, 2'd3, 4'd9, 1'b1, 1'b0, 1'b0);
        check("cfg_err_set", 16'(cfg_err), 16'd1);
        idle(2);
        cyc(2'b00, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("rst_mid", {7'h0, cfg_err, sig, flg, done, err}, 16'h0);
        idle(6);
        check("rst_no_sig", 16'(sig), 16'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [1:0] st, sp;
            st[0] = ($urandom_range(0, 15) == 0);
            st[1] = ($urandom_range(0, 15) == 0);
            sp[0] = ($urandom_range(0, 31) == 0);
            sp[1] = ($urandom_range(0, 31) == 0);
            cyc(st, sp, ($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
